// File: rtl/burst_mem_responder_pkg.sv
// Shared encodings for the burst memory responder: burst sizes, transfer
// direction and FSM states, plus the size-to-beat-count decode.
package burst_mem_responder_pkg;

  localparam logic [1:0] SZ_1W  = 2'b00;
  localparam logic [1:0] SZ_4W  = 2'b01;
  localparam logic [1:0] SZ_8W  = 2'b10;
  localparam logic [1:0] SZ_16W = 2'b11;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_BURST = 2'd1,
    ST_WR_BURST = 2'd2
  } state_t;

  // Index of the final beat of a burst (beat count minus one).
  function automatic logic [3:0] last_beat_index(input logic [1:0] size);
    case (size)
      SZ_1W:   last_beat_index = 4'd0;
      SZ_4W:   last_beat_index = 4'd3;
      SZ_8W:   last_beat_index = 4'd7;
      default: last_beat_index = 4'd15;
    endcase
  endfunction

endpackage

// File: rtl/burst_mem_responder_if.sv
// Pipeline memory bus carrying request, write data, busy and read data.
// The initiator drives through master; the memory responds through slave.
interface burst_mem_responder_if;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [1:0]  access_size;
  logic        rw;
  logic        enable;
  logic        busy;
  logic [31:0] data_out;

  modport master (
    output address, data_in, access_size, rw, enable,
    input  busy, data_out
  );

  modport slave (
    input  address, data_in, access_size, rw, enable,
    output busy, data_out
  );
endinterface

// File: rtl/burst_mem_responder_burst_addr_gen.sv
// Per-beat address generator: byte offset of the current beat, wrapped at
// the end of storage, and a flag marking the final beat of the burst.
module burst_addr_gen #(
  parameter int memory_depth = 1048576
) (
  input  logic [31:0] base_offset,
  input  logic [3:0]  beat,
  input  logic [3:0]  last_index,
  output logic [31:0] beat_offset,
  output logic        last_beat
);
  localparam logic [31:0] DEPTH = 32'(memory_depth);

  logic [31:0] sum;

  // base_offset < depth and the beat step is at most 60 < depth, so a single
  // conditional subtract is enough to wrap.
  assign sum         = base_offset + {26'd0, beat, 2'b00};
  assign beat_offset = (sum >= DEPTH) ? (sum - DEPTH) : sum;
  assign last_beat   = (beat == last_index);
endmodule

// File: rtl/burst_mem_responder.sv
// Memory-side responder with 1/4/8/16-word bursts over a big-endian byte
// array. Beat 0 is serviced on the acceptance edge itself; later beats come
// from the latched offset and a beat counter.
module burst_mem_responder
  import burst_mem_responder_pkg::*;
#(
  parameter logic [31:0] base_addr    = 32'h80020000,
  parameter int          memory_depth = 1048576
) (
  input  logic                  clock,
  input  logic                  reset,
  burst_mem_responder_if.slave  bus
);
  localparam int          AW    = $clog2(memory_depth);
  localparam logic [31:0] DEPTH = 32'(memory_depth);

  logic [7:0] mem [memory_depth];

  state_t      state_reg;
  logic [31:0] offset_reg;
  logic [3:0]  beat_reg;
  logic [3:0]  last_reg;
  logic        busy_reg;
  logic [31:0] data_out_reg;

  logic        accept;
  logic [31:0] accept_offset;
  logic [3:0]  accept_last;
  logic [31:0] gen_base;
  logic [3:0]  gen_beat;
  logic [3:0]  gen_last;
  logic [31:0] beat_off;
  logic        last_beat;
  logic        do_read;
  logic        do_write;
  logic [AW-1:0] lane_addr [4];

  assign accept        = bus.enable && !busy_reg && !reset;
  assign accept_offset = ((bus.address - base_addr) % DEPTH) & ~32'h3;
  assign accept_last   = last_beat_index(bus.access_size);

  // On the acceptance edge the generator sees the fresh request so beat 0
  // needs no extra cycle; otherwise it walks the latched burst.
  assign gen_base = accept ? accept_offset : offset_reg;
  assign gen_beat = accept ? 4'd0 : beat_reg;
  assign gen_last = accept ? accept_last : last_reg;

  burst_addr_gen #(.memory_depth(memory_depth)) u_addr_gen (
    .base_offset (gen_base),
    .beat        (gen_beat),
    .last_index  (gen_last),
    .beat_offset (beat_off),
    .last_beat   (last_beat)
  );

  // Offsets are word aligned and below depth, so only the word index bits matter.
  logic unused_beat_off;
  assign unused_beat_off = &{1'b0, beat_off};

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_addr[gi] = {beat_off[AW-1:2], 2'(gi)};
  end

  assign do_read  = (accept && bus.rw == RW_READ) || (state_reg == ST_RD_BURST);
  assign do_write = !reset &&
                    ((accept && bus.rw == RW_WRITE) || (state_reg == ST_WR_BURST));

  // Byte storage write port: one big-endian word per write beat.
  always_ff @(posedge clock) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        mem[lane_addr[i]] <= bus.data_in[31-8*i -: 8];
      end
    end
  end

  // Burst FSM with registered busy and read data.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      offset_reg   <= '0;
      beat_reg     <= '0;
      last_reg     <= '0;
      busy_reg     <= 1'b0;
      data_out_reg <= '0;
    end else begin
      if (do_read) begin
        data_out_reg <= {mem[lane_addr[0]], mem[lane_addr[1]],
                         mem[lane_addr[2]], mem[lane_addr[3]]};
      end
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            offset_reg <= accept_offset;
            last_reg   <= accept_last;
            beat_reg   <= 4'd1;
            if (accept_last != 4'd0) begin
              state_reg <= (bus.rw == RW_READ) ? ST_RD_BURST : ST_WR_BURST;
              busy_reg  <= 1'b1;
            end
          end
        end
        ST_RD_BURST, ST_WR_BURST: begin
          if (last_beat) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            beat_reg  <= 4'd0;
          end else begin
            beat_reg <= beat_reg + 4'd1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_reg;
  assign bus.data_out = data_out_reg;
endmodule

// File: tb/tb_burst_mem_responder.sv
// Directed bench for burst_mem_responder: single reads, write/read bursts,
// wrap at end of storage, ignored requests while busy, reset mid-burst and
// read-after-write.
module tb_burst_mem_responder;
  import burst_mem_responder_pkg::*;

  localparam logic [31:0] BASE  = 32'h80020000;
  localparam int          DEPTH = 1048576;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Bench-side copy of words 0..15 and of the last two words of storage.
  logic [31:0] model [16];
  logic [31:0] tail  [2];

  burst_mem_responder_if bus ();

  burst_mem_responder #(.base_addr(BASE), .memory_depth(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic poke_word(input int off, input logic [31:0] w);
    for (int i = 0; i < 4; i++) dut.mem[off + i] = w[31-8*i -: 8];
  endtask

  task automatic request(input logic [31:0] a, input logic [1:0] sz,
                         input logic r, input logic [31:0] d);
    bus.address     = a;
    bus.access_size = sz;
    bus.rw          = r;
    bus.data_in     = d;
    bus.enable      = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.enable = 1'b0;
    step();
    step();
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_busy: got %b expected 0", bus.busy);
    end
    n_cmp++;
    if (bus.data_out !== 32'h0) begin
      n_bad++; $display("FAIL reset_data_out: got %h expected 00000000", bus.data_out);
    end
    reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_single_read();
    request(BASE, SZ_1W, RW_READ, 32'h0);
    step();
    bus.enable = 1'b0;
    n_cmp++;
    if (bus.data_out !== 32'h12345678) begin
      n_bad++; $display("FAIL single_read: got %h expected 12345678", bus.data_out);
    end
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL single_read_busy: got %b expected 0", bus.busy);
    end
    $display("test_single_read data_out=%h", bus.data_out);
  endtask

  task automatic test_write_burst();
    int busy_cycles = 0;
    request(BASE + 32'h10, SZ_4W, RW_WRITE, 32'hA0);
    for (int k = 0; k < 4; k++) begin
      bus.data_in = 32'hA0 + 32'(k);
      step();
      bus.enable = 1'b0;
      if (bus.busy === 1'b1) busy_cycles++;
    end
    for (int k = 0; k < 4; k++) model[4 + k] = 32'hA0 + 32'(k);
    n_cmp++;
    if (busy_cycles != 3) begin
      n_bad++; $display("FAIL wr_burst_busy_cycles: got %0d expected 3", busy_cycles);
    end
    request(BASE + 32'h10, SZ_4W, RW_READ, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      bus.enable = 1'b0;
      n_cmp++;
      if (bus.data_out !== model[4 + k]) begin
        n_bad++; $display("FAIL rd4_beat%0d: got %h expected %h", k, bus.data_out, model[4 + k]);
      end
    end
    $display("test_write_burst busy_cycles=%0d", busy_cycles);
  endtask

  task automatic test_wrap();
    int busy_cycles = 0;
    logic [31:0] exp;
    request(BASE + 32'(DEPTH) - 32'd8, SZ_16W, RW_READ, 32'h0);
    for (int k = 0; k < 16; k++) begin
      step();
      bus.enable = 1'b0;
      if (bus.busy === 1'b1) busy_cycles++;
      exp = (k < 2) ? tail[k] : model[k - 2];
      n_cmp++;
      if (bus.data_out !== exp) begin
        n_bad++; $display("FAIL wrap_beat%0d: got %h expected %h", k, bus.data_out, exp);
      end
    end
    n_cmp++;
    if (busy_cycles != 15) begin
      n_bad++; $display("FAIL wrap_busy_cycles: got %0d expected 15", busy_cycles);
    end
    $display("test_wrap busy_cycles=%0d", busy_cycles);
  endtask

  task automatic test_ignore_busy();
    request(BASE, SZ_8W, RW_READ, 32'h0);
    step();
    n_cmp++;
    if (bus.data_out !== model[0]) begin
      n_bad++; $display("FAIL ign_beat0: got %h expected %h", bus.data_out, model[0]);
    end
    // Competing single read of word 4 held on the bus throughout.
    request(BASE + 32'h10, SZ_1W, RW_READ, 32'hFFFFFFFF);
    for (int k = 1; k < 8; k++) begin
      step();
      n_cmp++;
      if (bus.data_out !== model[k]) begin
        n_bad++; $display("FAIL ign_beat%0d: got %h expected %h", k, bus.data_out, model[k]);
      end
    end
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL ign_busy_end: got %b expected 0", bus.busy);
    end
    step();
    bus.enable = 1'b0;
    n_cmp++;
    if (bus.data_out !== model[4]) begin
      n_bad++; $display("FAIL ign_late_accept: got %h expected %h", bus.data_out, model[4]);
    end
    $display("test_ignore_busy late_data=%h", bus.data_out);
  endtask

  task automatic test_reset_mid_burst();
    request(BASE + 32'h30, SZ_4W, RW_WRITE, 32'h11);
    step();
    bus.enable  = 1'b0;
    bus.data_in = 32'h12;
    step();
    bus.data_in = 32'h13;
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.data_in = 32'h14;
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_busy: got %b expected 0", bus.busy);
    end
    n_cmp++;
    if (bus.data_out !== 32'h0) begin
      n_bad++; $display("FAIL rst_mid_data_out: got %h expected 00000000", bus.data_out);
    end
    model[12] = 32'h11;
    model[13] = 32'h12;
    step();
    request(BASE + 32'h30, SZ_4W, RW_READ, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      bus.enable = 1'b0;
      n_cmp++;
      if (bus.data_out !== model[12 + k]) begin
        n_bad++; $display("FAIL rst_mid_rb%0d: got %h expected %h", k, bus.data_out, model[12 + k]);
      end
    end
    $display("test_reset_mid_burst done");
  endtask

  task automatic test_read_after_write();
    logic [31:0] prev;
    prev = model[15];
    request(BASE + 32'h20, SZ_1W, RW_WRITE, 32'hCAFEF00D);
    step();
    n_cmp++;
    if (bus.data_out !== prev) begin
      n_bad++; $display("FAIL raw_write_hold: got %h expected %h", bus.data_out, prev);
    end
    request(BASE + 32'h20, SZ_1W, RW_READ, 32'h0);
    step();
    bus.enable = 1'b0;
    n_cmp++;
    if (bus.data_out !== 32'hCAFEF00D) begin
      n_bad++; $display("FAIL raw_read: got %h expected cafef00d", bus.data_out);
    end
    $display("test_read_after_write data_out=%h", bus.data_out);
  endtask

  initial begin
    bus.address = '0; bus.data_in = '0; bus.access_size = SZ_1W;
    bus.rw = RW_READ; bus.enable = 1'b0;
    for (int i = 0; i < 16; i++) model[i] = 32'h5A5A0000 + 32'(i);
    model[0] = 32'h12345678;
    tail[0] = 32'hDEAD0001;
    tail[1] = 32'hDEAD0002;
    for (int i = 0; i < 16; i++) poke_word(4 * i, model[i]);
    poke_word(DEPTH - 8, tail[0]);
    poke_word(DEPTH - 4, tail[1]);

    test_reset();
    test_single_read();
    test_write_burst();
    test_wrap();
    test_ignore_busy();
    test_reset_mid_burst();
    test_read_after_write();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/burst_mem_responder.md
Name: burst_mem_responder

Overview:
- Memory-side responder for the pipeline's memory bus: `address`, `data_in`, `access_size`, `rw`, `enable`, `busy`, `data_out`.
- Adds multi-word bursts, so a future cache or fetch-buffer initiator can move 1/4/8/16 words per request.
- Drops in wherever an IMEM/DMEM instance sits.
- Storage is a big-endian byte array, preloadable through hierarchical access.

Parameters:
- base_addr, 32'h80020000, byte address mapped to storage offset 0.
- memory_depth, 1048576, storage size in bytes; must be a multiple of 64.

Ports:
- clock  input  1  single clock; all logic on posedge.
- reset  input  1  synchronous, active-high.
- address  input  32  byte address of first beat, sampled at acceptance.
- data_in  input  32  write data; one beat sampled per edge during a write burst.
- access_size  input  2  burst length: 00=1, 01=4, 10=8, 11=16 words.
- rw  input  1  1=read, 0=write.
- enable  input  1  request valid.
- busy  output  1  burst in progress; new requests are not accepted.
- data_out  output  32  registered read data, one beat per cycle.

Behaviour:
- Reset values:
  - busy=0, data_out=0, FSM=IDLE, beat counter=0.
  - mem contents are not cleared.
- Acceptance: at a posedge with enable=1, busy=0 and reset=0.
  - Latch offset = (address - base_addr) with bits [1:0] forced to 0, taken modulo memory_depth.
  - Latch total beats N (1/4/8/16) and rw.
- FSM states: IDLE, RD_BURST, WR_BURST.
  - IDLE -> RD_BURST or WR_BURST on acceptance, only if N>1.
  - RD_BURST/WR_BURST -> IDLE after the edge that handles beat N-1.
- Read timing:
  - Beat k (k=0..N-1) appears on data_out after edge T0+k, where T0 is the acceptance edge.
  - Value is {mem[o],mem[o+1],mem[o+2],mem[o+3]}, with o = offset+4k mod memory_depth.
  - data_out holds the last beat until the next read acceptance; writes do not change data_out.
- Write timing:
  - Beat k: data_in sampled at edge T0+k and written big-endian to offset+4k mod memory_depth.
  - Single-word write completes at T0.
- busy: 1 after edge T0 through edge T0+N-2, i.e. exactly N-1 cycles; 0 for N=1.
  - A request can therefore be accepted at T0+N-1.
- While busy=1, enable, address, access_size and rw are ignored (burst parameters are latched). data_in is still sampled each write beat.
- Wrap-around: a burst crossing memory_depth wraps to offset 0; no error is signalled.
- Out-of-range address: reduced modulo memory_depth. No fault; the initiator owns range checking.
- Read-after-write, same word:
  - A read accepted the edge after a write beat returns the new data.
  - Within one edge, mem updates and data_out registers the pre-write value; a read and a write cannot co-occur.
- Reset mid-burst: FSM to IDLE, busy=0, data_out=0 next edge. Beats already written stay written; remaining beats are dropped.
- Counter/offset arithmetic is 32-bit unsigned. The beat counter is 4 bits (max 15).

Decomposition:
- Shared package holds:
  - access-size encodings: SZ_1W=2'b00, SZ_4W=2'b01, SZ_8W=2'b10, SZ_16W=2'b11;
  - rw encodings: RW_READ=1, RW_WRITE=0;
  - FSM state constants.
- One sub-module, burst_addr_gen:
  - takes latched offset, beat counter and memory_depth;
  - produces the wrapped byte offset of the current beat and a last-beat flag.

Test Plan:
1. Preload mem[0..3]=8'h12,34,56,78. Single read at 0x80020000, size 00 -> data_out=32'h12345678 after the acceptance edge; busy stays 0.
2. Write burst at 0x80020010, size 01, data_in 0xA0,0xA1,0xA2,0xA3 on consecutive edges -> busy=1 for 3 cycles, then a 4-beat read returns A0..A3 in order, one per cycle.
3. 16-beat read at base_addr+memory_depth-8 -> beats 0-1 from the last two words, beats 2-15 from offset 0 upward; busy=1 for exactly 15 cycles.
4. Assert enable with a new address/size while busy during an 8-beat read -> request ignored, original sequence unaffected; request accepted on the first edge busy=0.
5. Assert reset at beat 2 of a 4-beat write of 0x11..0x14 -> busy=0 and data_out=0 next cycle; readback shows words 0-1 written (0x11, 0x12) and words 2-3 unchanged.
6. Write 0xCAFEF00D at 0x80020020 (size 00), read the same address on the next edge -> data_out=0xCAFEF00D.
